// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, grant and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  // requester 0 (core load/store port)
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  // requester 1 (DMA / debug master)
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  // memory subsystem side
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // status
  logic          owner;
  logic          busy;

  // arbiter view
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_wdata,
    output owner, busy
  );

  // requester / memory-model view
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_wdata,
    input  owner, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for the shared data-memory port (option: ARB_FIXED_PRIO_EN)
module mem_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST_BEAT = 4'(MAX_BURST - 1);

  state_t        r_state;
  logic          r_last_owner;
  logic [3:0]    r_beat_cnt;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_own0;
  logic          w_own1;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_rd0;
  logic          w_rd1;
  logic          w_last_beat;
  logic          w_idle_pick1;
  logic          w_preempt_by0;
  logic          w_burst_limit0;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // Arbitration policy knobs: fixed priority favours requester 0 everywhere,
  // round-robin alternates ties and caps every owner at MAX_BURST beats.
`ifdef ARB_FIXED_PRIO_EN
  assign w_idle_pick1   = 1'b0;
  assign w_preempt_by0  = bus.req0;
  assign w_burst_limit0 = 1'b0;
`else
  assign w_idle_pick1   = (r_last_owner == 1'b0);
  assign w_preempt_by0  = 1'b0;
  assign w_burst_limit0 = 1'b1;
`endif

  assign w_own0      = (r_state == OWN0);
  assign w_own1      = (r_state == OWN1);
  assign w_acc0      = bus.req0 & w_own0;
  assign w_acc1      = bus.req1 & w_own1;
  assign w_rd0       = w_acc0 & ~bus.we0;
  assign w_rd1       = w_acc1 & ~bus.we1;
  assign w_last_beat = (r_beat_cnt == LP_LAST_BEAT);

  // Ownership FSM: grant state, burst counter and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || !w_idle_pick1)) begin
            r_state      <= OWN0;
            r_last_owner <= 1'b0;
            r_beat_cnt   <= '0;
          end else if (bus.req1) begin
            r_state      <= OWN1;
            r_last_owner <= 1'b1;
            r_beat_cnt   <= '0;
          end
        end
        OWN0: begin
          if (!bus.req0) begin
            if (bus.req1) begin
              r_state      <= OWN1;
              r_last_owner <= 1'b1;
              r_beat_cnt   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_last_beat) begin
            if (bus.req1 && w_burst_limit0) begin
              r_state      <= OWN1;
              r_last_owner <= 1'b1;
              r_beat_cnt   <= '0;
            end else begin
              r_beat_cnt <= '0;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
        OWN1: begin
          // a dropped req1 or a fixed-priority pre-emption both hand the port back
          if (!bus.req1 || w_preempt_by0) begin
            if (bus.req0) begin
              r_state      <= OWN0;
              r_last_owner <= 1'b0;
              r_beat_cnt   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_last_beat) begin
            if (bus.req0) begin
              r_state      <= OWN0;
              r_last_owner <= 1'b0;
              r_beat_cnt   <= '0;
            end else begin
              r_beat_cnt <= '0;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  // Read return: capture memory data at the acceptance edge, pulse rvalid one cycle later.
  // Tracks the requester that issued the beat, so it survives a same-edge handover.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) begin
        r_rdata0 <= bus.mem_rdata;
      end
      if (w_rd1) begin
        r_rdata1 <= bus.mem_rdata;
      end
    end
  end

  // Memory-side mux: last_owner is the current owner in OWN states and the previous one in IDLE
  assign w_mem_addr  = r_last_owner ? bus.addr1  : bus.addr0;
  assign w_mem_wdata = r_last_owner ? bus.wdata1 : bus.wdata0;

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = (w_acc0 & bus.we0) | (w_acc1 & bus.we1);

  assign bus.gnt0    = w_own0;
  assign bus.gnt1    = w_own1;
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign bus.owner   = r_last_owner;
  assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MB = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a ^ 16'h5A5A, a};
  endfunction

  assign bus.mem_rdata = mem_fn(bus.mem_addr);

  // reference model: 0 = IDLE, 1 = OWN0, 2 = OWN1
  logic [1:0]    m_state, m_ns;
  logic          m_last, m_nl;
  int            m_cnt, m_nc;
  logic          m_rv0, m_rv1;
  logic          m_a0, m_a1, m_we;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  assign m_a0 = bus.req0 && (m_state == 2'd1);
  assign m_a1 = bus.req1 && (m_state == 2'd2);
  assign m_we = (m_a0 && bus.we0) || (m_a1 && bus.we1);

  always_comb begin
    m_ns = m_state;
    m_nc = m_cnt;
    m_nl = m_last;
    case (m_state)
      2'd0: begin
        if (bus.req0 && (!bus.req1 || FIXED || m_last)) begin
          m_ns = 2'd1; m_nc = 0; m_nl = 1'b0;
        end else if (bus.req1) begin
          m_ns = 2'd2; m_nc = 0; m_nl = 1'b1;
        end
      end
      2'd1: begin
        if (bus.req0 && !(m_cnt == MB - 1 && bus.req1 && !FIXED))
          m_nc = (m_cnt == MB - 1) ? 0 : m_cnt + 1;
        else if (bus.req1) begin
          m_ns = 2'd2; m_nc = 0; m_nl = 1'b1;
        end else
          m_ns = 2'd0;
      end
      default: begin
        if (bus.req1 && !(FIXED && bus.req0) && !(m_cnt == MB - 1 && bus.req0))
          m_nc = (m_cnt == MB - 1) ? 0 : m_cnt + 1;
        else if (bus.req0) begin
          m_ns = 2'd1; m_nc = 0; m_nl = 1'b0;
        end else
          m_ns = 2'd0;
      end
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 2'd0;
      m_last  <= 1'b1;
      m_cnt   <= 0;
      m_rv0   <= 1'b0;
      m_rv1   <= 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      m_state <= m_ns;
      m_last  <= m_nl;
      m_cnt   <= m_nc;
      m_rv0   <= m_a0 && !bus.we0;
      m_rv1   <= m_a1 && !bus.we1;
      if (m_a0 && !bus.we0) q0.push_back(mem_fn(bus.addr0));
      if (m_a1 && !bus.we1) q1.push_back(mem_fn(bus.addr1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b, required 0", bus.gnt0); end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b, required 0", bus.gnt1); end
    n_checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b, required 00", bus.rvalid0, bus.rvalid1); end
    n_checks++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h, required 0 0", bus.rdata0, bus.rdata1); end
    n_checks++; if (bus.owner !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %b, required 1", bus.owner); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", bus.mem_we); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] e;
    do_reset();
    tick();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL read_no_comb_gnt: got %b, required 0", bus.gnt0); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL read_gnt: got %b%b, required 10", bus.gnt0, bus.gnt1); end
    n_checks++; if (bus.mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_mem_addr: got rdata %h addr %h, required DEADBEEF", bus.mem_rdata, bus.mem_addr); end
    tick();
    bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rvalid0 !== 1'b1) begin n_fail++; $display("FAIL read_rvalid0: got %b, required 1", bus.rvalid0); end
    n_checks++;
    if (q0.size() == 0) begin n_fail++; $display("FAIL read_scoreboard: got rdata0 %h, required nothing queued", bus.rdata0); end
    else begin
      e = q0.pop_front();
      if (bus.rdata0 !== e || e !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata0: got %h, required %h", bus.rdata0, e); end
    end
    n_checks++; if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL read_gnt1: got %b, required 0", bus.gnt1); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL read_rvalid_once: got %b, required 0", bus.rvalid0); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] e;
    int k, exp_own, got_own;
    k = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      tick();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0100 + 16'(c);
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0200 + 16'(c);
      @(negedge clk);
      n_checks++;
      if (bus.gnt0 !== (m_state == 2'd1) || bus.gnt1 !== (m_state == 2'd2)) begin
        n_fail++; $display("FAIL rr_grant c=%0d: got %b%b, required %b%b", c, bus.gnt0, bus.gnt1, m_state == 2'd1, m_state == 2'd2);
      end
      if ((bus.req0 && bus.gnt0) || (bus.req1 && bus.gnt1)) begin
        got_own = (bus.req1 && bus.gnt1) ? 1 : 0;
        exp_own = FIXED ? 0 : (k / MB) % 2;
        n_checks++;
        if (got_own !== exp_own) begin n_fail++; $display("FAIL rr_sequence beat=%0d: got owner %0d, required %0d", k, got_own, exp_own); end
        k++;
      end
      n_checks++;
      if (bus.rvalid0 !== m_rv0 || bus.rvalid1 !== m_rv1) begin n_fail++; $display("FAIL rr_rvalid c=%0d: got %b%b, required %b%b", c, bus.rvalid0, bus.rvalid1, m_rv0, m_rv1); end
      if (bus.rvalid0 && q0.size() > 0) begin
        e = q0.pop_front(); n_checks++;
        if (bus.rdata0 !== e) begin n_fail++; $display("FAIL rr_rdata0: got %h, required %h", bus.rdata0, e); end
      end
      if (bus.rvalid1 && q1.size() > 0) begin
        e = q1.pop_front(); n_checks++;
        if (bus.rdata1 !== e) begin n_fail++; $display("FAIL rr_rdata1: got %h, required %h", bus.rdata1, e); end
      end
    end
    n_checks++; if (k !== 25) begin n_fail++; $display("FAIL rr_beats: got %0d accepted beats, required 25", k); end
  endtask

  task automatic test_write();
    int n_we, n_rv;
    bit accepted;
    n_we = 0; n_rv = 0; accepted = 1'b0;
    do_reset();
    tick();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h8004; bus.wdata1 = 32'h12345678;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (accepted) bus.req1 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.mem_we !== m_we) begin n_fail++; $display("FAIL wr_mem_we c=%0d: got %b, required %b", c, bus.mem_we, m_we); end
      if (bus.mem_we) begin
        n_we++;
        n_checks++;
        if (bus.mem_addr !== 16'h8004 || bus.mem_wdata !== 32'h12345678) begin
          n_fail++; $display("FAIL wr_bus: got %h/%h, required 8004/12345678", bus.mem_addr, bus.mem_wdata);
        end
      end
      if (bus.rvalid0 || bus.rvalid1) n_rv++;
      if (bus.req1 && bus.gnt1) accepted = 1'b1;
    end
    n_checks++; if (n_we !== 1) begin n_fail++; $display("FAIL wr_once: got %0d write strobes, required 1", n_we); end
    n_checks++; if (n_rv !== 0) begin n_fail++; $display("FAIL wr_no_rvalid: got %0d pulses, required 0", n_rv); end
  endtask

  task automatic test_long_burst();
    logic [DW-1:0] e;
    int acc, rv;
    bit seen;
    acc = 0; rv = 0; seen = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      tick();
      bus.req0 = (acc < 10); bus.we0 = 1'b0; bus.addr0 = 16'h0300 + 16'(c);
      @(negedge clk);
      if (seen && acc < 10) begin
        n_checks++;
        if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL burst_bubble c=%0d: got gnt0 %b, required 1", c, bus.gnt0); end
      end
      if (bus.req0 && bus.gnt0) begin acc++; seen = 1'b1; end
      if (bus.rvalid0) begin
        rv++;
        n_checks++;
        if (q0.size() == 0) begin n_fail++; $display("FAIL burst_rvalid: got rvalid0 1, required 0"); end
        else begin
          e = q0.pop_front();
          if (bus.rdata0 !== e) begin n_fail++; $display("FAIL burst_rdata0: got %h, required %h", bus.rdata0, e); end
        end
      end
    end
    n_checks++; if (acc !== 10) begin n_fail++; $display("FAIL burst_beats: got %0d, required 10", acc); end
    n_checks++; if (rv !== 10) begin n_fail++; $display("FAIL burst_rvalid_count: got %0d, required 10", rv); end
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] e;
    do_reset();
    tick();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0400;
    tick();
    bus.addr1 = 16'h0404;
    @(negedge clk);
    n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL mid_gnt1: got %b, required 1", bus.gnt1); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rvalid1 !== 1'b1 || q1.size() == 0) begin n_fail++; $display("FAIL mid_first_rvalid: got %b, required 1", bus.rvalid1); end
    else begin
      e = q1.pop_front();
      if (bus.rdata1 !== e) begin n_fail++; $display("FAIL mid_first_rdata: got %h, required %h", bus.rdata1, e); end
    end
    tick();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0500;
    @(negedge clk);
    n_checks++; if (bus.gnt1 !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got gnt1 %b busy %b, required 0 0", bus.gnt1, bus.busy); end
    n_checks++; if (bus.rvalid1 !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid_dropped: got %b, required 0", bus.rvalid1); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_mem_we: got %b, required 0", bus.mem_we); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL mid_regrant: got %b%b, required 10", bus.gnt0, bus.gnt1); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    tick();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0600;
    tick();
    tick();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0700;
    @(negedge clk);
    n_checks++; if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL fp_before: got gnt1 %b, required 1", bus.gnt1); end
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL fp_preempt c=%0d: got %b%b, required 10", c, bus.gnt0, bus.gnt1); end
    end
    tick();
    bus.req0 = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL fp_return: got %b%b, required 01", bus.gnt0, bus.gnt1); end
    bus.req1 = 1'b0;
  endtask
`endif

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_long_burst();
    test_reset_mid_burst();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
